// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code decoder and sequence checker with lock tracking.
// Optional JOHNSON_DEC_HOLD_EN: accept a repeated code (stalled counter) without error.
module johnson_decoder #(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 3,
  localparam int IW       = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  output logic [IW-1:0] idx,
  output logic          idx_valid,
  output logic          illegal,
  output logic          step_err,
  output logic          wrap,
  output logic          locked,
  output logic [7:0]    err_count,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ref_idx;
  logic [3:0]    good;

  int            trans;
  int            ones;
  logic          legal;
  logic [IW-1:0] dec;
  logic [IW-1:0] succ;
  logic          at_top;
  logic [3:0]    good_inc;
  logic [7:0]    err_inc;

  // A legal Johnson code has at most one 0/1 boundary between adjacent stages.
  always_comb begin
    trans = 0;
    ones  = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (code_in[i] != code_in[i+1]) trans++;
    end
    for (int i = 0; i < N; i++) begin
      ones += int'(code_in[i]);
    end
    legal = (trans <= 1);
    if (code_in[0] || (code_in == '0)) dec = IW'(ones);
    else                               dec = IW'(2 * N - ones);
    at_top   = (ref_idx == IW'(2 * N - 1));
    succ     = at_top ? '0 : ref_idx + IW'(1);
    good_inc = good + 4'd1;
    err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  assign locked    = (state == LOCKED);
  assign state_dbg = state;

  // code_valid qualifies code_in for one cycle; there is no backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      ref_idx   <= '0;
      good      <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;
      wrap      <= 1'b0;
      if (code_valid) begin
        if (!legal) begin
          illegal <= 1'b1;
          if (state == LOCKED) err_count <= err_inc;
          state <= HUNT;
        end else begin
          idx       <= dec;
          idx_valid <= 1'b1;
          case (state)
            HUNT: begin
              ref_idx <= dec;
              good    <= '0;
              state   <= TRACK;
            end
            TRACK: begin
              if (dec == succ) begin
                ref_idx <= dec;
                good    <= good_inc;
                if (good_inc == 4'(LOCK_CNT)) state <= LOCKED;
`ifdef JOHNSON_DEC_HOLD_EN
              end else if (dec == ref_idx) begin
                good <= good;
`endif
              end else begin
                ref_idx <= dec;
                good    <= '0;
              end
            end
            LOCKED: begin
              if (dec == succ) begin
                ref_idx <= dec;
                wrap    <= at_top;
`ifdef JOHNSON_DEC_HOLD_EN
              end else if (dec == ref_idx) begin
                good <= good;
`endif
              end else begin
                step_err  <= 1'b1;
                err_count <= err_inc;
                ref_idx   <= dec;
                good      <= '0;
                state     <= TRACK;
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (N=4, LOCK_CNT=3) with queue-based scoreboard.
module tb_johnson_decoder;

  localparam logic [3:0] C0 = 4'b0000, C1 = 4'b0001, C2 = 4'b0011, C3 = 4'b0111;
  localparam logic [3:0] C4 = 4'b1111, C5 = 4'b1110, C6 = 4'b1100, C7 = 4'b1000;
  localparam logic [3:0] BAD_A = 4'b0101, BAD_B = 4'b1011;
`ifdef JOHNSON_DEC_HOLD_EN
  localparam logic H = 1'b1;
`else
  localparam logic H = 1'b0;
`endif
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic [2:0] idx;
  logic       idx_valid, illegal, step_err, wrap, locked;
  logic [7:0] err_count;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   e;

  johnson_decoder dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .idx(idx), .idx_valid(idx_valid), .illegal(illegal), .step_err(step_err),
    .wrap(wrap), .locked(locked), .err_count(err_count), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic s(input logic [3:0] c, input logic v, input logic [2:0] ei, input logic eiv,
                   input logic eill, input logic ese, input logic ewr, input logic elk,
                   input logic [7:0] ee, input string name);
    @(negedge clk);
    rst = 1'b0; code_in = c; code_valid = v;
    @(posedge clk);
    exp_q.push_back({ei, eiv, eill, ese, ewr, elk, ee});
    tag_q.push_back(name);
  endtask

  task automatic do_reset(input logic [3:0] c, input string name);
    @(negedge clk);
    rst = 1'b1; code_in = c; code_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back('0);
    tag_q.push_back(name);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] got, want;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = tag_q.pop_front();
        got  = {idx, idx_valid, illegal, step_err, wrap, locked, err_count};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got {idx,iv,ill,se,wrap,lock,err}=%h expected %h", nm, got, want);
        end
      end
    end
  end

  initial begin
    do_reset(C3, "reset_a");
    do_reset(C3, "reset_b");
    // full sequence, lock after 4th sample, wrap on 7->0
    s(C0, 1, 0, 1, 0, 0, 0, 0, 0, "seq0");
    s(C1, 1, 1, 1, 0, 0, 0, 0, 0, "seq1");
    s(C2, 1, 2, 1, 0, 0, 0, 0, 0, "seq2");
    s(C3, 1, 3, 1, 0, 0, 0, 1, 0, "seq3_lock");
    s(C4, 1, 4, 1, 0, 0, 0, 1, 0, "seq4");
    s(C5, 1, 5, 1, 0, 0, 0, 1, 0, "seq5");
    s(C6, 1, 6, 1, 0, 0, 0, 1, 0, "seq6");
    s(C7, 1, 7, 1, 0, 0, 0, 1, 0, "seq7");
    s(C0, 1, 0, 1, 0, 0, 1, 1, 0, "seq_wrap");
    // illegal while locked
    s(BAD_A, 1, 0, 0, 1, 0, 0, 0, 1, "illegal_locked");
    s(C2, 1, 2, 1, 0, 0, 0, 0, 1, "hunt_to_track");
    s(C3, 1, 3, 1, 0, 0, 0, 0, 1, "relock_a1");
    s(C4, 1, 4, 1, 0, 0, 0, 0, 1, "relock_a2");
    s(C5, 1, 5, 1, 0, 0, 0, 1, 1, "relock_a3");
    s(C6, 1, 6, 1, 0, 0, 0, 1, 1, "run_6");
    s(C7, 1, 7, 1, 0, 0, 0, 1, 1, "run_7");
    s(C0, 1, 0, 1, 0, 0, 1, 1, 1, "run_wrap");
    s(C1, 1, 1, 1, 0, 0, 0, 1, 1, "run_1");
    s(C2, 1, 2, 1, 0, 0, 0, 1, 1, "run_2");
    // step error while locked at 2
    s(C4, 1, 4, 1, 0, 1, 0, 0, 2, "step_err");
    s(C5, 1, 5, 1, 0, 0, 0, 0, 2, "relock_b1");
    s(C6, 1, 6, 1, 0, 0, 0, 0, 2, "relock_b2");
    s(C7, 1, 7, 1, 0, 0, 0, 1, 2, "relock_b3");
    s(C0, 1, 0, 1, 0, 0, 1, 1, 2, "run_wrap2");
    s(C1, 1, 1, 1, 0, 0, 0, 1, 2, "run_1b");
    s(C2, 1, 2, 1, 0, 0, 0, 1, 2, "run_2b");
    s(C3, 1, 3, 1, 0, 0, 0, 1, 2, "run_3b");
    // repeated code: hold accepted or step error
    e = H ? 8'd2 : 8'd3;
    s(C3, 1, 3, 1, 0, !H, 0, H, e, "repeat_code");
    s(C4, 1, 4, 1, 0, 0, 0, H, e, "after_rep4");
    s(C5, 1, 5, 1, 0, 0, 0, H, e, "after_rep5");
    s(C6, 1, 6, 1, 0, 0, 0, 1, e, "after_rep6");
    // code_valid low with garbage on the bus
    s(BAD_A, 0, 6, 0, 0, 0, 0, 1, e, "gap_a");
    s(4'b1010, 0, 6, 0, 0, 0, 0, 1, e, "gap_b");
    s(C0, 0, 6, 0, 0, 0, 0, 1, e, "gap_c");
    s(C2, 0, 6, 0, 0, 0, 0, 1, e, "gap_d");
    s(4'b1001, 0, 6, 0, 0, 0, 0, 1, e, "gap_e");
    s(C7, 1, 7, 1, 0, 0, 0, 1, e, "resume");
    s(C0, 1, 0, 1, 0, 0, 1, 1, e, "resume_wrap");
    s(C1, 1, 1, 1, 0, 0, 0, 1, e, "pre_sat1");
    s(C2, 1, 2, 1, 0, 0, 0, 1, e, "pre_sat2");
    s(C3, 1, 3, 1, 0, 0, 0, 1, e, "pre_sat3");
    // 300 errors alternating illegal / step error, relocking to ref 3 each time
    for (int i = 0; i < 300; i++) begin
      e = (e == 8'hFF) ? e : e + 8'd1;
      if (i % 2 == 0) begin
        s(BAD_A, 1, 3, 0, 1, 0, 0, 0, e, "sat_ill");
        s(C0, 1, 0, 1, 0, 0, 0, 0, e, "sat_i0");
        s(C1, 1, 1, 1, 0, 0, 0, 0, e, "sat_i1");
        s(C2, 1, 2, 1, 0, 0, 0, 0, e, "sat_i2");
        s(C3, 1, 3, 1, 0, 0, 0, 1, e, "sat_i3");
      end else begin
        s(C6, 1, 6, 1, 0, 1, 0, 0, e, "sat_step");
        s(C7, 1, 7, 1, 0, 0, 0, 0, e, "sat_s7");
        s(C0, 1, 0, 1, 0, 0, 0, 0, e, "sat_s0");
        s(C1, 1, 1, 1, 0, 0, 0, 1, e, "sat_s1");
        s(C2, 1, 2, 1, 0, 0, 0, 1, e, "sat_s2");
        s(C3, 1, 3, 1, 0, 0, 0, 1, e, "sat_s3");
      end
    end
    s(C4, 1, 4, 1, 0, 0, 0, 1, 8'd255, "saturated");
    // reset with concurrent valid sample, then HUNT behaviour
    do_reset(C5, "reset_mid");
    s(C5, 1, 5, 1, 0, 0, 0, 0, 0, "post_reset");
    s(BAD_B, 1, 5, 0, 1, 0, 0, 0, 0, "illegal_track");
    s(C5, 1, 5, 1, 0, 0, 0, 0, 0, "hunt_again");
    @(negedge clk);
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receiving-end decoder and sequence checker for twisted-ring (Johnson) counter codes. Samples an N-bit Johnson code each valid cycle, converts it to a binary index in 0..2N-1, flags illegal codes and out-of-sequence steps, and tracks lock to a correctly advancing counter. Sits downstream of any Johnson counter in the design, where the code crosses a block boundary or is used as a phase/state bus.

## Interface
- N, default 4: code width in stages; sequence length 2N; N >= 2.
- LOCK_CNT, default 3: consecutive correct successor steps required to assert lock; 1..15.
- IW, default $clog2(2*N): index width (derived, not overridden).
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- code_in  input  N  Johnson code; bit 0 is the stage fed by the inverted MSB.
- code_valid  input  1  sample qualifier; code_in ignored when low.
- idx  output  IW  last legal decoded index; held between legal samples.
- idx_valid  output  1  one-cycle pulse: legal sample decoded this cycle.
- illegal  output  1  one-cycle pulse: sampled code not a Johnson code.
- step_err  output  1  one-cycle pulse: legal code but not the expected successor, while locked.
- wrap  output  1  one-cycle pulse: locked step from 2N-1 to 0.
- locked  output  1  level, high in LOCKED state.
- err_count  output  8  saturating count of illegal and step_err pulses raised while locked.

## Operation
- Legality: code legal iff code_in[i] != code_in[i+1] for at most one i in 0..N-2. Yields exactly 2N legal codes.
- Decode: p = popcount(code_in). If code_in[0]==1 or code_in==0: idx = p; else idx = 2N - p. N=4: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7.
- Successor: next = (ref + 1) mod 2N; ref = previously stored legal index.
- States: HUNT (no reference), TRACK (reference held, counting good steps), LOCKED.
- HUNT: legal -> store ref, good=0, go TRACK. Illegal -> illegal pulse, stay.
- TRACK: successor -> ref updates, good+1; when good reaches LOCK_CNT go LOCKED. Legal non-successor -> ref = new idx, good=0, stay. Illegal -> illegal pulse, go HUNT.
- LOCKED: successor -> stay; wrap pulse if ref==2N-1. Legal non-successor -> step_err, err_count+1, ref = new idx, good=0, go TRACK. Illegal -> illegal, err_count+1, go HUNT.
- step_err never raised outside LOCKED; err_count only increments in LOCKED; saturates at 255.
- code_valid low: no state, ref, good or count change; all pulses low.
- idx updates on every legal sample in any state, unchanged on illegal.

## Timing
- Single register stage: code sampled at edge k, all outputs reflect it after edge k; no combinational input-to-output path.
- Reset values: idx=0, idx_valid=0, illegal=0, step_err=0, wrap=0, locked=0, err_count=0; state HUNT, good=0.
- rst mid-operation overrides everything, including a concurrent code_valid; sample discarded.
- Lock: with LOCK_CNT=3 and gap-free correct stream, locked rises after the 4th legal sample (1 reference + 3 steps).
- locked drops in the same cycle the step_err/illegal pulse is raised.

## Configuration
- JOHNSON_DEC_HOLD_EN defined: legal code equal to ref (counter stalled) accepted in TRACK and LOCKED; no error, good unchanged, state unchanged, idx_valid pulses.
- Not defined: repeated code treated as legal non-successor (step_err and drop to TRACK if LOCKED; good reset to 0 if TRACK).

## Test plan
- Reset then full N=4 sequence 0000..1000,0000 with code_valid=1 every cycle -> idx 0..7,0; locked high from 4th sample; wrap pulse once on 7->0; err_count=0.
- Locked, inject 0101 -> illegal pulse, locked=0, err_count=1, state HUNT; next 0011 -> idx=2, TRACK.
- Locked at idx 2, inject 1111 (idx 4) -> step_err, err_count+1, locked=0; then 1110,1100,1000 -> relocks after 3rd.
- Locked at idx 3, repeat 0111 -> with JOHNSON_DEC_HOLD_EN: no error, locked stays 1; without: step_err, locked=0.
- code_valid low for 5 cycles mid-stream with code_in toggling garbage -> no pulses, idx and locked unchanged; resume at successor -> no error.
- Force 300 illegal/step errors while relocking between -> err_count saturates at 255; rst asserted with code_valid=1 -> all outputs 0 next cycle.
